// File: rtl/p_logic_pkg.sv
// Op codes and helper functions shared by the bitwise reduction pipeline.
package p_logic_pkg;

  localparam int unsigned MAX_W = 256;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_RSVD6 = 3'd6,
    OP_RSVD7 = 3'd7
  } op_e;

  function automatic op_e base_op(op_e op);
    op_e b;
    b = OP_AND;
    unique case (1'b1)
      (op == OP_OR) || (op == OP_NOR):   b = OP_OR;
      (op == OP_XOR) || (op == OP_XNOR): b = OP_XOR;
      default:                           b = OP_AND;
    endcase
    return b;
  endfunction

  function automatic logic is_inverting(op_e op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

  function automatic logic is_reserved(op_e op);
    return (op == OP_RSVD6) || (op == OP_RSVD7);
  endfunction

  // AND family pads with all ones in the low w bits; OR/XOR pad with zero.
  function automatic logic [MAX_W-1:0] identity_word(op_e op, int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    if (base_op(op) == OP_AND) r = {MAX_W{1'b1}} >> (MAX_W - w);
    return r;
  endfunction

endpackage

// File: rtl/p_reduce_stage.sv
// One registered level of the reduction tree with valid/ready handshake.
module p_reduce_stage
  import p_logic_pkg::*;
#(
  parameter int W = 8,
  parameter int N_IN = 2,
  parameter bit LAST = 1'b0,
  localparam int N_OUT = (N_IN + 1) / 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  op_e          in_op,
  input  logic [W-1:0] in_data [N_IN],
  output logic         out_valid,
  input  logic         out_ready,
  output op_e          out_op,
  output logic [W-1:0] out_data [N_OUT],
  output logic         out_zero,
  output logic         out_ones
);

  op_e          base;
  logic [W-1:0] id;
  logic [W-1:0] res [N_OUT];
  logic         zero_d;
  logic         ones_d;

  assign base = base_op(in_op);
  assign id   = W'(identity_word(in_op, W));

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    localparam int IB = (2 * j + 1 < N_IN) ? 2 * j + 1 : 2 * j;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;

    assign a = in_data[2 * j];
    assign b = (2 * j + 1 < N_IN) ? in_data[IB] : id;

    always_comb begin
      c = a & b;
      unique case (1'b1)
        base == OP_OR:  c = a | b;
        base == OP_XOR: c = a ^ b;
        default:        c = a & b;
      endcase
    end

    // Only the root applies inversion and the reserved-op clamp.
    assign res[j] = (LAST && is_reserved(in_op))  ? '0 :
                    (LAST && is_inverting(in_op)) ? ~c : c;
  end

  assign zero_d = LAST && (res[0] == '0);
  assign ones_d = LAST && (&res[0]);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op    <= OP_AND;
      out_zero  <= 1'b0;
      out_ones  <= 1'b0;
      for (int j = 0; j < N_OUT; j++) out_data[j] <= '0;
    end else begin
      if (in_ready) out_valid <= in_valid;
      if (in_valid && in_ready) begin
        out_op   <= in_op;
        out_zero <= zero_d;
        out_ones <= ones_d;
        for (int j = 0; j < N_OUT; j++) out_data[j] <= res[j];
      end
    end
  end

endmodule

// File: rtl/p_reduce_pipe.sv
// Pipelined multi-bus bitwise reducer built from registered tree levels.
module p_reduce_pipe
  import p_logic_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int NB_INS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [BUS_WIDTH-1:0] in_buses [NB_INS],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_bus,
  output logic                 out_zero,
  output logic                 out_ones
);

  localparam int LEVELS = $clog2(NB_INS);
  localparam int NS = (LEVELS < 1) ? 1 : LEVELS;

  logic vld [NS+1];
  logic rdy [NS+1];
  op_e  opc [NS+1];
  logic zero_f [NS];
  logic ones_f [NS];

  assign vld[0]    = in_valid;
  assign opc[0]    = op_e'(in_op);
  assign in_ready  = rdy[0];
  assign rdy[NS]   = out_ready;
  assign out_valid = vld[NS];
  assign out_zero  = zero_f[NS-1];
  assign out_ones  = ones_f[NS-1];

  for (genvar k = 0; k < NS; k++) begin : g_lvl
    localparam int NI = (NB_INS + (1 << k) - 1) >> k;
    localparam int NO = (NI + 1) / 2;
    logic [BUS_WIDTH-1:0] d [NO];

    if (k == 0) begin : g_head
      p_reduce_stage #(
        .W(BUS_WIDTH), .N_IN(NI), .LAST(k == NS - 1)
      ) u_stage (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vld[k]), .in_ready(rdy[k]),
        .in_op(opc[k]), .in_data(in_buses),
        .out_valid(vld[k+1]), .out_ready(rdy[k+1]),
        .out_op(opc[k+1]), .out_data(d),
        .out_zero(zero_f[k]), .out_ones(ones_f[k])
      );
    end else begin : g_body
      p_reduce_stage #(
        .W(BUS_WIDTH), .N_IN(NI), .LAST(k == NS - 1)
      ) u_stage (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vld[k]), .in_ready(rdy[k]),
        .in_op(opc[k]), .in_data(g_lvl[k-1].d),
        .out_valid(vld[k+1]), .out_ready(rdy[k+1]),
        .out_op(opc[k+1]), .out_data(d),
        .out_zero(zero_f[k]), .out_ones(ones_f[k])
      );
    end
  end

  assign out_bus = g_lvl[NS-1].d[0];

endmodule

// File: tb/tb_p_reduce_pipe.sv
// Self-checking bench for p_reduce_pipe at NB_INS = 5, 1 and 64.
module tb_p_reduce_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int pass_n = 0;
  int tot_n = 0;
  int npop = 0;

  logic       m_iv = 1'b0;
  logic       m_ordy = 1'b1;
  logic [2:0] m_op = 3'd0;
  logic [7:0] m_bus [5];
  logic       m_irdy, m_ov, m_zero, m_ones;
  logic [7:0] m_out;

  logic       s_iv = 1'b0;
  logic [2:0] s_op = 3'd0;
  logic [3:0] s_bus [1];
  logic       s_irdy, s_ov, s_zero, s_ones;
  logic [3:0] s_out;

  logic       b_iv = 1'b0;
  logic [2:0] b_op = 3'd0;
  logic [7:0] b_bus [64];
  logic       b_irdy, b_ov, b_zero, b_ones;
  logic [7:0] b_out;

  p_reduce_pipe #(.BUS_WIDTH(8), .NB_INS(5)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_irdy),
    .in_op(m_op), .in_buses(m_bus), .out_valid(m_ov),
    .out_ready(m_ordy), .out_bus(m_out), .out_zero(m_zero),
    .out_ones(m_ones)
  );

  p_reduce_pipe #(.BUS_WIDTH(4), .NB_INS(1)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_irdy),
    .in_op(s_op), .in_buses(s_bus), .out_valid(s_ov),
    .out_ready(1'b1), .out_bus(s_out), .out_zero(s_zero),
    .out_ones(s_ones)
  );

  p_reduce_pipe #(.BUS_WIDTH(8), .NB_INS(64)) u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_irdy),
    .in_op(b_op), .in_buses(b_bus), .out_valid(b_ov),
    .out_ready(1'b1), .out_bus(b_out), .out_zero(b_zero),
    .out_ones(b_ones)
  );

  typedef struct packed {
    logic [7:0] bus;
    logic       z;
    logic       o;
  } exp_t;

  typedef struct packed {
    logic [2:0]      op;
    logic [4:0][7:0] v;
    logic [7:0]      bus;
    logic            z;
    logic            o;
  } vec_t;

  exp_t       q [$];
  logic       held = 1'b0;
  logic [9:0] held_val = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  // Reduction from the op table: fold n words of width w, then invert/clamp.
  function automatic logic [7:0] model(input logic [2:0] op,
                                       input logic [7:0] v [64],
                                       input int n, input int w);
    logic [7:0] m, acc;
    m = 8'((1 << w) - 1);
    acc = (op == 3'd0 || op == 3'd3) ? m : 8'h00;
    for (int i = 0; i < n; i++) begin
      case (op)
        3'd0, 3'd3: acc = acc & v[i];
        3'd1, 3'd4: acc = acc | v[i];
        3'd2, 3'd5: acc = acc ^ v[i];
        default: ;
      endcase
    end
    if (op >= 3'd3 && op <= 3'd5) acc = ~acc & m;
    if (op >= 3'd6) acc = 8'h00;
    return acc;
  endfunction

  task automatic m_rand();
    m_op = 3'($urandom_range(0, 7));
    for (int i = 0; i < 5; i++) m_bus[i] = 8'($urandom);
  endtask

  // One clock of the main DUT: scoreboard both handshakes, then advance.
  task automatic cyc();
    logic [7:0] v [64];
    exp_t e;
    #1;
    if (held)
      chk("hold_stable", 32'({m_ov, m_out, m_zero, m_ones}),
          32'({1'b1, held_val}));
    if (m_ov && m_ordy) begin
      if (q.size() == 0) begin
        tot_n++;
        $display("FAIL unexpected_out: got %0h, required none", m_out);
      end else begin
        e = q.pop_front();
        npop++;
        chk("sb_bus", 32'(m_out), 32'(e.bus));
        chk("sb_zero", 32'(m_zero), 32'(e.z));
        chk("sb_ones", 32'(m_ones), 32'(e.o));
      end
    end
    held = m_ov && !m_ordy;
    held_val = {m_out, m_zero, m_ones};
    if (m_iv && m_irdy) begin
      v = '{default: 8'h00};
      for (int i = 0; i < 5; i++) v[i] = m_bus[i];
      e.bus = model(m_op, v, 5, 8);
      e.z = (e.bus == 8'h00);
      e.o = (e.bus == 8'hFF);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [7];
    int         lat;
    logic       seen;
    logic [7:0] v [64];
    logic [7:0] ex;
    int         k;

    for (int i = 0; i < 5; i++) m_bus[i] = 8'h00;
    s_bus[0] = 4'h0;
    for (int i = 0; i < 64; i++) b_bus[i] = 8'h00;

    tbl[0] = '{3'd0, {8'hFF, 8'hF0, 8'h3C, 8'hFF, 8'hFF}, 8'h30, 1'b0, 1'b0};
    tbl[1] = '{3'd1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 8'h01, 1'b0, 1'b0};
    tbl[2] = '{3'd2, {8'h01, 8'h02, 8'h04, 8'h08, 8'h10}, 8'h1F, 1'b0, 1'b0};
    tbl[3] = '{3'd3, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{3'd4, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'hFF, 1'b0, 1'b1};
    tbl[5] = '{3'd7, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{3'd0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'hFF, 1'b0, 1'b1};

    #12;
    chk("rst_out_valid", 32'(m_ov), 32'(0));
    chk("rst_out_bus", 32'(m_out), 32'(0));
    chk("rst_out_zero", 32'(m_zero), 32'(0));
    chk("rst_out_ones", 32'(m_ones), 32'(0));
    chk("rst_in_ready", 32'(m_irdy), 32'(1));
    chk("rst_small_valid", 32'(s_ov), 32'(0));
    chk("rst_big_valid", 32'(b_ov), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 7; t++) begin
      m_op = tbl[t].op;
      for (int i = 0; i < 5; i++) m_bus[i] = tbl[t].v[i];
      m_iv = 1'b1;
      cyc();
      m_iv = 1'b0;
      lat = 1;
      while (!m_ov && lat < 10) begin
        cyc();
        lat++;
      end
      chk("vec_latency", 32'(lat), 32'(3));
      chk("vec_bus", 32'(m_out), 32'(tbl[t].bus));
      chk("vec_zero", 32'(m_zero), 32'(tbl[t].z));
      chk("vec_ones", 32'(m_ones), 32'(tbl[t].o));
      cyc();
    end

    npop = 0;
    for (int i = 0; i < 20; i++) begin
      m_rand();
      m_iv = 1'b1;
      chk("stream_in_ready", 32'(m_irdy), 32'(1));
      cyc();
    end
    m_iv = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("stream_count", 32'(npop), 32'(20));
    chk("stream_empty", 32'(q.size()), 32'(0));

    for (int i = 0; i < 4; i++) begin
      m_rand();
      m_iv = (i % 2 == 0);
      cyc();
    end
    m_ordy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_rand();
      m_iv = 1'b1;
      cyc();
    end
    chk("bp_in_ready_low", 32'(m_irdy), 32'(0));
    chk("bp_out_valid", 32'(m_ov), 32'(1));
    m_ordy = 1'b1;
    m_iv = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("bp_drain", 32'(q.size()), 32'(0));

    for (int i = 0; i < 300; i++) begin
      m_rand();
      m_iv = 1'($urandom_range(0, 1));
      m_ordy = ($urandom_range(0, 3) != 0);
      cyc();
    end
    m_iv = 1'b0;
    m_ordy = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    chk("mix_drain", 32'(q.size()), 32'(0));

    m_ordy = 1'b0;
    m_rand();
    m_iv = 1'b1;
    cyc();
    m_rand();
    cyc();
    m_iv = 1'b0;
    cyc();
    chk("pre_rst_valid", 32'(m_ov), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(m_ov), 32'(0));
    chk("rst_async_bus", 32'(m_out), 32'(0));
    chk("rst_async_zero", 32'(m_zero), 32'(0));
    chk("rst_async_ones", 32'(m_ones), 32'(0));
    q.delete();
    held = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ordy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      seen = seen | m_ov;
    end
    chk("no_stale_after_rst", 32'(seen), 32'(0));

    s_op = 3'd5;
    s_bus[0] = 4'hA;
    s_iv = 1'b1;
    cyc();
    s_iv = 1'b0;
    chk("s_lat1_valid", 32'(s_ov), 32'(1));
    chk("s_xnor_bus", 32'(s_out), 32'(4'h5));
    chk("s_xnor_zero", 32'(s_zero), 32'(0));
    chk("s_xnor_ones", 32'(s_ones), 32'(0));
    cyc();
    chk("s_idle_valid", 32'(s_ov), 32'(0));
    for (int r = 0; r < 8; r++) begin
      s_op = 3'($urandom_range(0, 7));
      s_bus[0] = 4'($urandom);
      v = '{default: 8'h00};
      v[0] = {4'h0, s_bus[0]};
      ex = model(s_op, v, 1, 4);
      s_iv = 1'b1;
      cyc();
      s_iv = 1'b0;
      chk("s_rand_bus", 32'(s_out), 32'(ex));
      chk("s_rand_zero", 32'(s_zero), 32'(ex == 8'h00));
    end

    for (int r = 0; r < 6; r++) begin
      b_op = 3'(r);
      k = $urandom_range(0, 63);
      for (int i = 0; i < 64; i++) begin
        if (r == 2 || r == 5) b_bus[i] = 8'($urandom);
        else if (r == 0 || r == 3) b_bus[i] = 8'hFF;
        else b_bus[i] = 8'h00;
      end
      b_bus[k] = 8'($urandom);
      for (int i = 0; i < 64; i++) v[i] = b_bus[i];
      ex = model(b_op, v, 64, 8);
      b_iv = 1'b1;
      cyc();
      b_iv = 1'b0;
      lat = 1;
      while (!b_ov && lat < 20) begin
        cyc();
        lat++;
      end
      chk("b_latency", 32'(lat), 32'(6));
      chk("b_bus", 32'(b_out), 32'(ex));
      chk("b_ones", 32'(b_ones), 32'(ex == 8'hFF));
      cyc();
    end

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule

// File: doc/p_reduce_pipe.md
Name: p_reduce_pipe

Overview:
- Pipelined, parametrised multi-bus bitwise reducer: the next generation of the combinational multi-input AND primitives in the boolean library.
- Reduces NB_INS buses of BUS_WIDTH bits with a run-time selectable operation: AND, OR, XOR, NAND, NOR or XNOR.
- Uses a registered binary tree with valid/ready handshake on both sides.
- Sits between register-file/ALU operand muxes and the flag logic; gives full throughput at a fixed latency.

Parameters:
- BUS_WIDTH, 8, bit width of every input bus and of the result.
- NB_INS, 4, number of input buses; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set and op are valid this cycle.
- in_ready  output  1  block accepts the operand set this cycle.
- in_op  input  3  operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
- in_buses  input  BUS_WIDTH x NB_INS (unpacked array)  operand buses.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_bus  output  BUS_WIDTH  reduction result.
- out_zero  output  1  out_bus == 0.
- out_ones  output  1  out_bus == all ones.

Behaviour:
- Reset: single clock domain; rst_n is asynchronous and active-low. While rst_n = 0, every stage valid = 0, every data/op register = 0, out_valid = 0, out_bus = 0, out_zero = 0, out_ones = 0. Reset deasserting mid-stream discards all in-flight data; no partial result is ever presented.
- Structure: LEVELS = clog2(NB_INS). There is one register stage per tree level. Latency L = max(LEVELS, 1) cycles from the accept edge to out_valid.
  - NB_INS = 1: a single pass-through register stage. The base op is still applied, so the identity is used and inversion applies.
- Tree level k: combines adjacent pairs of level k-1 with the base op (AND for AND/NAND, OR for OR/NOR, XOR for XOR/XNOR).
  - Odd element counts: pad to a power of two with the identity element (all ones for AND, all zeros for OR/XOR). Padding must not change the result.
- The op code is registered alongside the data at every stage.
- Inversion (NAND/NOR/XNOR) is applied in the final stage before the output register.
- Reserved op 6/7: the result is forced to 0, with out_zero = 1 and out_ones = 0. This is not an error.
- out_zero and out_ones are registered together with out_bus and are only meaningful when out_valid = 1.
- Handshake, per stage s:
  - ready_s = !valid_s || ready_(s+1); the last stage uses out_ready.
  - in_ready = ready_0.
  - A transfer occurs on a clock edge where valid && ready.
  - No combinational path from in_valid to in_ready.
  - The combinational path from out_ready to in_ready through the ready chain is permitted.
- Full throughput: one result per cycle while out_ready = 1. Pipeline bubbles are collapsed by a waiting downstream stage.
- Backpressure: while out_valid && !out_ready, out_bus, out_zero and out_ones hold stable. Upstream stages keep filling until each is full, then in_ready = 0.
- Simultaneous events: on the same edge a full stage may hand its data downstream and accept new data from upstream. Data is never lost or duplicated.
- in_buses and in_op are sampled only on an accepting edge; they are don't-care otherwise.

Decomposition:
- Package p_logic_pkg holds:
  - the 3-bit op enum (OP_AND .. OP_XNOR, OP_RSVD6, OP_RSVD7);
  - a function returning the base op for an op;
  - a function returning the identity word for a given BUS_WIDTH;
  - an is_inverting function.
- Sub-module p_reduce_stage implements one tree level. Its parameters are width, input count and last-stage flag. It contains the pairwise combine, pad, optional final invert/flags, the register and the valid/ready logic. The top module instantiates LEVELS of these through generate.

Test Plan:
- BUS_WIDTH=8, NB_INS=5, L=3; out_ready=1; op AND; inputs FF,F0,3C,FF,FF -> out_bus 30 three cycles after the accept edge; out_zero=0, out_ones=0.
- Same config, padding check:
  - op OR, inputs 00,00,00,00,01 -> 01;
  - op XOR, inputs 01,02,04,08,10 -> 1F;
  - op NAND, all FF -> 00 with out_zero=1;
  - op NOR, all 00 -> FF with out_ones=1.
- Streaming: 20 back-to-back random sets with out_ready=1 -> 20 results in order, one per cycle, in_ready constantly 1, each matching the reference model.
- Backpressure: hold out_ready=0 for 6 cycles while streaming -> in_ready falls once all 3 stages are full, out_bus stays stable, and on release every result appears in order with none lost.
- Reserved op 7 with inputs FF x5 -> out_bus 00, out_zero=1; then rst_n pulsed low for 1 cycle with 2 items in flight -> out_valid 0 immediately (asynchronous), and no stale result after release.
- NB_INS=1, BUS_WIDTH=4: op XNOR, input A -> out_bus 5 after 1 cycle. NB_INS=64 random smoke test: latency 6.
